// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI read-channel widths, master indices and arbiter state encoding
//
// Purpose : common definitions for the read arbiter and its round-robin picker.
// Ports   : none (package).
package axi_pkg;

    localparam int ID_W    = 4;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int LOCK_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int DATA_W  = 32;
    localparam int RESP_W  = 2;

    localparam int MST_ICACHE   = 0;
    localparam int MST_DCACHE   = 1;
    localparam int MST_UNCACHED = 2;

    localparam logic [ID_W-1:0] ARID_ICACHE   = 4'd0;
    localparam logic [ID_W-1:0] ARID_DCACHE   = 4'd1;
    localparam logic [ID_W-1:0] ARID_UNCACHED = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational N-way round-robin priority encoder
//
// Purpose : picks the first requester after the previous owner, wrapping around.
// Ports   : req        - per-master request vector
//           last_owner - index of the most recent owner
//           winner     - selected master index (0 when nothing requests)
//           valid      - at least one master requests
module rr_picker
    import axi_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    always_comb begin
        int idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        // The previous owner is visited last, so it only wins when alone.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_owner) + k) % N;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - round-robin owner arbiter for the shared AXI read channel
//
// Purpose : grants the single AR/R channel to one of N read masters, routes the
//           owner's AR slice to the slave and the slave's R beats to the owner,
//           and holds ownership until the owner withdraws its request.
// Ports   : clk, rst                    - clock, synchronous active-high reset
//           m_req / m_grnt              - per-master request / registered one-hot grant
//           AXI_Load_Bus_busy           - arbiter not idle
//           m_ar* / m_arvalid/m_arready - packed per-master AR channels
//           m_r* / m_rvalid / m_rready  - broadcast R fields, per-master handshake
//           ar* / arvalid / arready     - AR channel towards the slave
//           r* / rvalid / rready        - R channel from the slave
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter int N_MASTERS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_req,
    output logic [N_MASTERS-1:0]          m_grnt,
    output logic                          AXI_Load_Bus_busy,
    input  logic [N_MASTERS*ID_W-1:0]     m_arid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_araddr,
    input  logic [N_MASTERS*LEN_W-1:0]    m_arlen,
    input  logic [N_MASTERS*SIZE_W-1:0]   m_arsize,
    input  logic [N_MASTERS*BURST_W-1:0]  m_arburst,
    input  logic [N_MASTERS*LOCK_W-1:0]   m_arlock,
    input  logic [N_MASTERS*CACHE_W-1:0]  m_arcache,
    input  logic [N_MASTERS*PROT_W-1:0]   m_arprot,
    input  logic [N_MASTERS-1:0]          m_arvalid,
    output logic [N_MASTERS-1:0]          m_arready,
    output logic [ID_W-1:0]               m_rid,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [RESP_W-1:0]             m_rresp,
    output logic                          m_rlast,
    output logic [N_MASTERS-1:0]          m_rvalid,
    input  logic [N_MASTERS-1:0]          m_rready,
    output logic [ID_W-1:0]               arid,
    output logic [ADDR_W-1:0]             araddr,
    output logic [LEN_W-1:0]              arlen,
    output logic [SIZE_W-1:0]             arsize,
    output logic [BURST_W-1:0]            arburst,
    output logic [LOCK_W-1:0]             arlock,
    output logic [CACHE_W-1:0]            arcache,
    output logic [PROT_W-1:0]             arprot,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [ID_W-1:0]               rid,
    input  logic [DATA_W-1:0]             rdata,
    input  logic [RESP_W-1:0]             rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    function automatic logic [N_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_MASTERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    arb_state_t       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_owner;
    logic             ar_seen;
    logic [IDX_W-1:0] pick_winner;
    logic             pick_valid;

    logic [ID_W-1:0]    arid_s    [N_MASTERS];
    logic [ADDR_W-1:0]  araddr_s  [N_MASTERS];
    logic [LEN_W-1:0]   arlen_s   [N_MASTERS];
    logic [SIZE_W-1:0]  arsize_s  [N_MASTERS];
    logic [BURST_W-1:0] arburst_s [N_MASTERS];
    logic [LOCK_W-1:0]  arlock_s  [N_MASTERS];
    logic [CACHE_W-1:0] arcache_s [N_MASTERS];
    logic [PROT_W-1:0]  arprot_s  [N_MASTERS];

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_slice
        assign arid_s[i]    = m_arid[i*ID_W +: ID_W];
        assign araddr_s[i]  = m_araddr[i*ADDR_W +: ADDR_W];
        assign arlen_s[i]   = m_arlen[i*LEN_W +: LEN_W];
        assign arsize_s[i]  = m_arsize[i*SIZE_W +: SIZE_W];
        assign arburst_s[i] = m_arburst[i*BURST_W +: BURST_W];
        assign arlock_s[i]  = m_arlock[i*LOCK_W +: LOCK_W];
        assign arcache_s[i] = m_arcache[i*CACHE_W +: CACHE_W];
        assign arprot_s[i]  = m_arprot[i*PROT_W +: PROT_W];
    end

    logic owner_req;
    logic owner_arvalid;
    logic owner_rready;

    assign owner_req     = m_req[owner];
    assign owner_arvalid = m_arvalid[owner];
    assign owner_rready  = m_rready[owner];

    rr_picker #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (m_req),
        .last_owner (last_owner),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            owner             <= '0;
            last_owner        <= IDX_W'(N_MASTERS - 1);
            m_grnt            <= '0;
            AXI_Load_Bus_busy <= 1'b0;
            ar_seen           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state             <= ST_ADDR;
                        owner             <= pick_winner;
                        last_owner        <= pick_winner;
                        m_grnt            <= onehot(pick_winner);
                        AXI_Load_Bus_busy <= 1'b1;
                        ar_seen           <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (owner_arvalid) begin
                        ar_seen <= 1'b1;
                    end
                    if (owner_arvalid && arready) begin
                        state <= ST_DATA;
                    end else if (!owner_req && !owner_arvalid && !ar_seen) begin
                        // Owner gave up before presenting an address: nothing is
                        // outstanding at the slave, so the channel can be freed.
                        state             <= ST_IDLE;
                        m_grnt            <= '0;
                        AXI_Load_Bus_busy <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (rvalid && owner_rready && rlast) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Keep the grant until the owner leaves its post-data delay,
                    // otherwise it would be re-granted with a stale request.
                    if (!owner_req) begin
                        state             <= ST_IDLE;
                        m_grnt            <= '0;
                        AXI_Load_Bus_busy <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        arid      = '0;
        araddr    = '0;
        arlen     = '0;
        arsize    = '0;
        arburst   = '0;
        arlock    = '0;
        arcache   = '0;
        arprot    = '0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        if (state == ST_ADDR || state == ST_DATA) begin
            arid    = arid_s[owner];
            araddr  = araddr_s[owner];
            arlen   = arlen_s[owner];
            arsize  = arsize_s[owner];
            arburst = arburst_s[owner];
            arlock  = arlock_s[owner];
            arcache = arcache_s[owner];
            arprot  = arprot_s[owner];
        end
        if (state == ST_ADDR) begin
            arvalid          = owner_arvalid;
            m_arready[owner] = arready;
        end
        if (state == ST_DATA) begin
            rready          = owner_rready;
            m_rvalid[owner] = rvalid;
        end
    end

    // Beats go to the owner whatever their rid; the id is only passed through.
    assign m_rid   = rid;
    assign m_rdata = rdata;
    assign m_rresp = rresp;
    assign m_rlast = rlast;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - scoreboard bench for axi_read_arbiter
module tb_axi_read_arbiter;
    import axi_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [N-1:0]           m_req, m_grnt;
    logic                   busy;
    logic [N*ID_W-1:0]      m_arid;
    logic [N*ADDR_W-1:0]    m_araddr;
    logic [N*LEN_W-1:0]     m_arlen;
    logic [N*SIZE_W-1:0]    m_arsize;
    logic [N*BURST_W-1:0]   m_arburst;
    logic [N*LOCK_W-1:0]    m_arlock;
    logic [N*CACHE_W-1:0]   m_arcache;
    logic [N*PROT_W-1:0]    m_arprot;
    logic [N-1:0]           m_arvalid, m_arready;
    logic [ID_W-1:0]        m_rid;
    logic [DATA_W-1:0]      m_rdata;
    logic [RESP_W-1:0]      m_rresp;
    logic                   m_rlast;
    logic [N-1:0]           m_rvalid, m_rready;
    logic [ID_W-1:0]        arid;
    logic [ADDR_W-1:0]      araddr;
    logic [LEN_W-1:0]       arlen;
    logic [SIZE_W-1:0]      arsize;
    logic [BURST_W-1:0]     arburst;
    logic [LOCK_W-1:0]      arlock;
    logic [CACHE_W-1:0]     arcache;
    logic [PROT_W-1:0]      arprot;
    logic                   arvalid, arready;
    logic [ID_W-1:0]        rid;
    logic [DATA_W-1:0]      rdata;
    logic [RESP_W-1:0]      rresp;
    logic                   rlast, rvalid, rready;

    axi_read_arbiter #(.N_MASTERS(N)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_grnt(m_grnt), .AXI_Load_Bus_busy(busy),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct { int mst; logic [ADDR_W-1:0] addr; logic [ID_W-1:0] id; logic [LEN_W-1:0] len; } ar_exp_t;
    typedef struct { int mst; logic [DATA_W-1:0] data; logic [RESP_W-1:0] resp; logic [ID_W-1:0] id; logic last; } r_exp_t;

    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];
    int      grant_q[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit force_dead = 1'b0;
    int model_last = N - 1;

    logic [ADDR_W-1:0] p_addr[N];
    int                p_len[N];
    int                p_hold[N];
    bit                p_abandon[N];
    int                p_rst_beat[N];

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT shows a grant, AR or R handshake.
    initial begin
        logic [N-1:0] prev_grnt;
        ar_exp_t a;
        r_exp_t  r;
        int      g;
        prev_grnt = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_grnt == '0 && m_grnt != '0) begin
                    if (grant_q.size() == 0) check("unexpected_grant", m_grnt, '0);
                    else begin
                        g = grant_q.pop_front();
                        check("grant_order", m_grnt, onehot(g));
                    end
                end
                prev_grnt = m_grnt;
                check("busy_vs_grant", busy, |m_grnt);
                check("arready_route", m_arready & ~m_grnt, '0);
                check("rvalid_route", m_rvalid & ~m_grnt, '0);
                if (arvalid && arready) begin
                    if (ar_q.size() == 0) check("unexpected_ar", araddr, '0);
                    else begin
                        a = ar_q.pop_front();
                        check("ar_addr", araddr, a.addr);
                        check("ar_id", arid, a.id);
                        check("ar_len", arlen, a.len);
                        check("ar_size_burst", {arsize, arburst}, {3'd2, 2'd1});
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (m_rvalid[i] && m_rready[i]) begin
                        if (r_q.size() == 0) check("unexpected_beat", i, 99);
                        else begin
                            r = r_q.pop_front();
                            check("r_master", i, r.mst);
                            check("r_data", m_rdata, r.data);
                            check("r_resp_id_last", {m_rresp, m_rid, m_rlast}, {r.resp, r.id, r.last});
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        timeout("watchdog");
    end

    task automatic randomize_params();
        for (int i = 0; i < N; i++) begin
            p_addr[i]     = $urandom & 32'hFFFF_FFFC;
            p_len[i]      = $urandom_range(0, 15);
            p_hold[i]     = $urandom_range(0, 3);
            p_abandon[i]  = 1'b0;
            p_rst_beat[i] = -1;
        end
    endtask

    task automatic load_slices();
        for (int i = 0; i < N; i++) begin
            m_arid[i*ID_W +: ID_W]          = ID_W'(i);
            m_araddr[i*ADDR_W +: ADDR_W]    = p_addr[i];
            m_arlen[i*LEN_W +: LEN_W]       = LEN_W'(p_len[i]);
            m_arsize[i*SIZE_W +: SIZE_W]    = 3'd2;
            m_arburst[i*BURST_W +: BURST_W] = 2'd1;
            m_arlock[i*LOCK_W +: LOCK_W]    = 2'd0;
            m_arcache[i*CACHE_W +: CACHE_W] = 4'h3;
            m_arprot[i*PROT_W +: PROT_W]    = 3'd0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; m_req = '0; m_arvalid = '0; arready = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; m_rready = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_grant", m_grnt, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_gates", {arvalid, rready, m_arready, m_rvalid}, '0);
        grant_q.delete(); ar_q.delete(); r_q.delete();
        model_last = N - 1;
    endtask

    task automatic release_check(input int e);
        @(negedge clk);
        check("release_not_early", m_grnt, onehot(e));
        @(posedge clk); @(negedge clk);
        check("release_grant", m_grnt, '0);
        check("release_busy", busy, 1'b0);
    endtask

    // Caller is just after a rising edge; returns just after a rising edge.
    task automatic run_round(input logic [N-1:0] mask);
        int ord[$];
        int idx, e, g, wait_c;
        bit hs, aborted;
        ar_exp_t a;
        r_exp_t  r;
        aborted = 1'b0;
        // Reference: pending masters are served in cyclic order after the previous winner.
        for (int d = 1; d <= N; d++) begin
            idx = (model_last + d) % N;
            if (mask[idx]) ord.push_back(idx);
        end
        model_last = ord[$];
        foreach (ord[k]) grant_q.push_back(ord[k]);
        load_slices();
        m_req = m_req | mask;
        for (int k = 0; k < ord.size() && !aborted; k++) begin
            e = ord[k];
            @(posedge clk); @(negedge clk);
            check("grant_latency", m_grnt != '0, 1'b1);
            wait_c = 0;
            while (m_grnt == '0 && wait_c < 20) begin
                @(negedge clk);
                wait_c++;
            end
            if (m_grnt == '0) timeout("grant_wait");
            g = 0;
            for (int i = 0; i < N; i++) if (m_grnt[i]) g = i;
            @(posedge clk); #1;
            if (p_abandon[g]) begin
                arready = 1'b1;
                @(negedge clk);
                check("abandon_no_arvalid", arvalid, 1'b0);
                @(posedge clk); #1;
                m_req[g] = 1'b0;
                arready  = 1'b0;
            end else begin
                a.mst = e; a.addr = p_addr[e]; a.id = ID_W'(e); a.len = LEN_W'(p_len[e]);
                ar_q.push_back(a);
                repeat ($urandom_range(0, 2)) begin
                    arready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                m_arvalid[g] = 1'b1;
                hs = 1'b0;
                for (int c = 0; c < 50 && !hs; c++) begin
                    arready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    hs = arvalid && arready;
                    @(posedge clk); #1;
                end
                if (!hs) timeout("ar_handshake");
                m_arvalid[g] = 1'b0;
                arready      = 1'b0;
                for (int b = 0; b <= p_len[g]; b++) begin
                    if (b == p_rst_beat[g]) begin
                        do_reset();
                        aborted = 1'b1;
                        break;
                    end
                    r.mst  = e;
                    r.data = force_dead ? 32'hDEAD_BEEF : $urandom;
                    r.resp = RESP_W'($urandom_range(0, 3));
                    r.id   = ID_W'($urandom);
                    r.last = (b == p_len[e]);
                    r_q.push_back(r);
                    rdata = r.data; rresp = r.resp; rid = r.id; rlast = (b == p_len[g]);
                    rvalid = 1'b0;
                    hs = 1'b0;
                    for (int c = 0; c < 60 && !hs; c++) begin
                        if (!rvalid) rvalid = ($urandom_range(0, 3) != 0);
                        m_rready = N'($urandom);
                        @(negedge clk);
                        hs = rvalid && rready;
                        @(posedge clk); #1;
                    end
                    if (!hs) timeout("r_handshake");
                end
                if (!aborted) begin
                    // Slave keeps driving junk during HOLD; none of it may reach a master.
                    rvalid = 1'b1; rlast = 1'b1; m_rready = '1;
                    for (int h = 0; h < p_hold[g]; h++) begin
                        @(negedge clk);
                        check("hold_grant", m_grnt, onehot(e));
                        check("hold_gated", {arvalid, rready, |m_rvalid, |araddr}, '0);
                        @(posedge clk); #1;
                    end
                    rvalid = 1'b0; rlast = 1'b0; m_rready = '0;
                    m_req[g] = 1'b0;
                    check("beats_drained", r_q.size(), 0);
                end
            end
            if (!aborted) release_check(e);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; m_req = '0; m_arvalid = '0; m_rready = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        randomize_params();
        load_slices();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_grant", m_grnt, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_gates", {arvalid, rready, m_arready, m_rvalid}, '0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Single uncached read
        randomize_params();
        p_addr[MST_UNCACHED] = 32'h1FD0_F000; p_len[MST_UNCACHED] = 0; p_hold[MST_UNCACHED] = 2;
        force_dead = 1'b1;
        run_round(3'b100);
        force_dead = 1'b0;

        // Contention: all three at once
        randomize_params();
        run_round(3'b111);

        // Burst on D-cache with I-cache... then HOLD with the loader waiting
        randomize_params();
        run_round(3'b001);
        randomize_params();
        p_len[MST_DCACHE] = 7; p_hold[MST_DCACHE] = 3;
        run_round(3'b110);

        // Abandon before any arvalid
        randomize_params();
        p_abandon[MST_ICACHE] = 1'b1;
        run_round(3'b001);

        // Reset in the middle of a burst, then master 0 must win first
        randomize_params();
        p_len[MST_DCACHE] = 7; p_rst_beat[MST_DCACHE] = 3;
        run_round(3'b010);
        randomize_params();
        run_round(3'b111);

        for (int n = 0; n < 40; n++) begin
            randomize_params();
            for (int i = 0; i < N; i++) p_abandon[i] = ($urandom_range(0, 7) == 0);
            run_round(N'($urandom_range(1, (1 << N) - 1)));
        end

        repeat (3) @(negedge clk);
        check("grant_q_empty", grant_q.size(), 0);
        check("ar_q_empty", ar_q.size(), 0);
        check("r_q_empty", r_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
